// File: rtl/nn_mac_layer_if.sv
// Handshake and config bundle for nn_mac_layer.
// master: the side driving samples, coefficients and out_ready.
// slave : the MAC layer itself.
interface nn_mac_layer_if #(
    parameter int DATA_W = 8,
    parameter int WGT_W  = 8,
    parameter int N_HID  = 2
);
    localparam int CFG_AW = $clog2(3*N_HID+1);

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              cfg_we;
    logic [CFG_AW-1:0] cfg_addr;
    logic [WGT_W-1:0]  cfg_wdata;
    logic              sat_flag;

    modport master (
        output in_valid, in_data, out_ready, cfg_we, cfg_addr, cfg_wdata,
        input  in_ready, out_valid, out_data, sat_flag
    );

    modport slave (
        input  in_valid, in_data, out_ready, cfg_we, cfg_addr, cfg_wdata,
        output in_ready, out_valid, out_data, sat_flag
    );
endinterface

// File: rtl/nn_mac_layer.sv
// Time-multiplexed two-layer neural net on one shared multiply-accumulate.
// Hidden neurons: h[i] = clamp(x*w[i] + b[i]); output: y = clamp(sum v[i]*h[i] + c).
// Optional macro NN_SAT_FLAG_EN: enables the sticky upper-clamp indicator sat_flag;
// when undefined sat_flag is tied low and the detection logic is absent.
//
// state | meaning
// IDLE  | ready for a sample, config writes accepted
// HID   | one hidden neuron per cycle into h[idx]
// OUT   | acc += v[idx]*h[idx], one term per cycle
// FIN   | phase 0 adds output bias c, phase 1 clamps acc into out_data
// DONE  | result held until out_ready
module nn_mac_layer #(
    parameter int DATA_W = 8,
    parameter int WGT_W  = 8,
    parameter int N_HID  = 2
) (
    input logic            clk,
    input logic            rst_n,
    nn_mac_layer_if.slave  bus
);
    localparam int CFG_AW = $clog2(3*N_HID+1);
    localparam int ACC_W  = DATA_W + WGT_W + $clog2(N_HID+1) + 2;
    localparam int IDX_W  = (N_HID > 1) ? $clog2(N_HID) : 1;
    localparam int N_COEF = 3*N_HID + 1;
    localparam logic [IDX_W-1:0]        IDX_LAST = IDX_W'(N_HID-1);
    localparam logic signed [ACC_W-1:0] Z_MAX    = ACC_W'((1 << DATA_W) - 1);

    typedef enum logic [2:0] {S_IDLE, S_HID, S_OUT, S_FIN, S_DONE} state_t;

    function automatic logic over_max(input logic signed [ACC_W-1:0] z);
        return z > Z_MAX;
    endfunction

    function automatic logic [DATA_W-1:0] clamp(input logic signed [ACC_W-1:0] z);
        if (z[ACC_W-1])
            return '0;
        else if (z > Z_MAX)
            return '1;
        else
            return z[DATA_W-1:0];
    endfunction

    function automatic logic signed [ACC_W-1:0] sx(input logic [WGT_W-1:0] c);
        return {{(ACC_W-WGT_W){c[WGT_W-1]}}, c};
    endfunction

    function automatic logic signed [ACC_W-1:0] zx(input logic [DATA_W-1:0] d);
        return {{(ACC_W-DATA_W){1'b0}}, d};
    endfunction

    state_t                    state_q, state_d;
    logic [WGT_W-1:0]          coef [N_COEF];
    logic [DATA_W-1:0]         h_q  [N_HID];
    logic [DATA_W-1:0]         x_q;
    logic [DATA_W-1:0]         out_q;
    logic [IDX_W-1:0]          idx_q;
    logic                      fin_q;
    logic signed [ACC_W-1:0]   acc_q;

    logic [CFG_AW-1:0]         a_w, a_b, a_v;
    logic signed [ACC_W-1:0]   hid_z, out_term;
    logic                      accept, cfg_hit, idx_last;

    assign accept   = bus.in_valid && (state_q == S_IDLE);
    assign cfg_hit  = bus.cfg_we && (state_q == S_IDLE) && (bus.cfg_addr <= CFG_AW'(3*N_HID));
    assign idx_last = (idx_q == IDX_LAST);

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.out_data  = out_q;

    // Shared MAC operands: coefficient addresses follow the config map layout.
    always_comb begin
        a_w      = CFG_AW'(idx_q);
        a_b      = a_w + CFG_AW'(N_HID);
        a_v      = a_w + CFG_AW'(2*N_HID);
        hid_z    = zx(x_q) * sx(coef[a_w]) + sx(coef[a_b]);
        out_term = sx(coef[a_v]) * zx(h_q[idx_q]);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (bus.in_valid)  state_d = S_HID;
            S_HID:  if (idx_last)      state_d = S_OUT;
            S_OUT:  if (idx_last)      state_d = S_FIN;
            S_FIN:  if (fin_q)         state_d = S_DONE;
            S_DONE: if (bus.out_ready) state_d = S_IDLE;
            default:                   state_d = S_IDLE;
        endcase
    end

    // Coefficient file and datapath; a config write on the accept edge is seen by that sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_COEF; i++) coef[i] <= '0;
            for (int i = 0; i < N_HID; i++)  h_q[i]  <= '0;
            x_q   <= '0;
            out_q <= '0;
            idx_q <= '0;
            fin_q <= 1'b0;
            acc_q <= '0;
        end else begin
            if (cfg_hit)
                coef[bus.cfg_addr] <= bus.cfg_wdata;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        x_q   <= bus.in_data;
                        idx_q <= '0;
                        acc_q <= '0;
                        fin_q <= 1'b0;
                    end
                end
                S_HID: begin
                    h_q[idx_q] <= clamp(hid_z);
                    idx_q      <= idx_last ? '0 : idx_q + 1'b1;
                end
                S_OUT: begin
                    acc_q <= acc_q + out_term;
                    idx_q <= idx_last ? '0 : idx_q + 1'b1;
                end
                S_FIN: begin
                    if (!fin_q) begin
                        acc_q <= acc_q + sx(coef[N_COEF-1]);
                        fin_q <= 1'b1;
                    end else begin
                        out_q <= clamp(acc_q);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef NN_SAT_FLAG_EN
    logic sat_q;

    // Sticky record of any upper clamp, hidden or output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sat_q <= 1'b0;
        else if ((state_q == S_HID && over_max(hid_z)) ||
                 (state_q == S_FIN && fin_q && over_max(acc_q)))
            sat_q <= 1'b1;
    end

    assign bus.sat_flag = sat_q;
`else
    assign bus.sat_flag = 1'b0;
`endif

endmodule

// File: tb/tb_nn_mac_layer.sv
// Directed bench for nn_mac_layer (N_HID=2) with an expected-result queue.
module tb_nn_mac_layer;
    localparam int DATA_W = 8;
    localparam int WGT_W  = 8;
    localparam int N_HID  = 2;
    localparam int CFG_AW = $clog2(3*N_HID+1);
`ifdef NN_SAT_FLAG_EN
    localparam logic EXP_SAT = 1'b1;
`else
    localparam logic EXP_SAT = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    nn_mac_layer_if #(.DATA_W(DATA_W), .WGT_W(WGT_W), .N_HID(N_HID)) bus ();

    nn_mac_layer #(.DATA_W(DATA_W), .WGT_W(WGT_W), .N_HID(N_HID)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic cfg_write(input int addr, input int data);
        logic [31:0] a, d;
        a = addr;
        d = data;
        @(negedge clk);
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = a[CFG_AW-1:0];
        bus.cfg_wdata = d[WGT_W-1:0];
        @(negedge clk);
        bus.cfg_we    = 1'b0;
    endtask

    task automatic load(input int w0, input int w1, input int b0, input int b1,
                        input int v0, input int v1, input int c);
        cfg_write(0, w0); cfg_write(1, w1);
        cfg_write(2, b0); cfg_write(3, b1);
        cfg_write(4, v0); cfg_write(5, v1);
        cfg_write(6, c);
    endtask

    task automatic drive_noise();
        bus.in_valid  = ~bus.in_valid;
        bus.in_data   = 8'($urandom);
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = '0;
        bus.cfg_wdata = 8'd7;
    endtask

    task automatic run_sample(input string tag, input int x, input int exp, input int hold,
                              input bit noisy, input logic exp_sat);
        logic [31:0] xv;
        int cycles;
        int got;
        xv = x;
        exp_q.push_back(exp);
        @(negedge clk);
        check({tag, "_in_ready_idle"}, bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.in_data  = xv[DATA_W-1:0];
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
        cycles = 0;
        while (bus.out_valid !== 1'b1 && cycles < 20) begin
            if (noisy) drive_noise();
            @(posedge clk);
            #1;
            cycles++;
        end
        check({tag, "_latency"}, cycles, 6);
        got = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        for (int i = 0; i < hold; i++) begin
            check({tag, "_hold_valid"}, bus.out_valid, 1);
            check({tag, "_hold_data"}, bus.out_data, got);
            check({tag, "_hold_ready"}, bus.in_ready, 0);
            if (noisy) drive_noise();
            @(posedge clk);
            #1;
        end
        check({tag, "_out_data"}, bus.out_data, got);
        check({tag, "_sat"}, bus.sat_flag, exp_sat);
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.cfg_we    = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check({tag, "_valid_drop"}, bus.out_valid, 0);
        check({tag, "_ready_rise"}, bus.in_ready, 1);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        bus.cfg_we    = 1'b0;
        bus.cfg_addr  = '0;
        bus.cfg_wdata = '0;

        #2 rst_n = 1'b0;
        #20;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_data", bus.out_data, 0);
        check("rst_sat", bus.sat_flag, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Baseline: h=(16,23), y=16+46+5=67.
        load(2, 1, 10, 20, 1, 2, 5);
        run_sample("base_x3", 3, 67, 0, 1'b0, 1'b0);

        // Negative w0 drives h0 below zero: h=(0,70), y=145, no saturation.
        cfg_write(0, 8'hFF);
        run_sample("lowclamp_x50", 50, 145, 0, 1'b0, 1'b0);
        cfg_write(0, 2);

        // h=(210,120), sum 455 clamps to 255; sticky flag survives a normal sample.
        run_sample("sat_x100", 100, 255, 0, 1'b0, EXP_SAT);
        run_sample("sticky_x3", 3, 67, 0, 1'b0, EXP_SAT);

        // Stall with toggling in_valid and cfg writes to w[0]; both must be ignored.
        run_sample("stall_x3", 3, 67, 10, 1'b1, EXP_SAT);
        run_sample("after_stall_x3", 3, 67, 0, 1'b0, EXP_SAT);

        // Out-of-range address write has no effect.
        cfg_write(7, 8'h55);
        run_sample("oob_x3", 3, 67, 2, 1'b0, EXP_SAT);

        // Reset while in OUT: outputs return to reset values immediately.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'd3;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_out_data", bus.out_data, 0);
        check("midrst_in_ready", bus.in_ready, 1);
        check("midrst_sat", bus.sat_flag, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Coefficients cleared: everything evaluates to 0.
        run_sample("noload_x200", 200, 0, 0, 1'b0, 1'b0);
        load(2, 1, 10, 20, 1, 2, 5);
        run_sample("reload_x3", 3, 67, 0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/nn_mac_layer.md
# nn_mac_layer

Parametrised, time-multiplexed two-layer neural net: one unsigned scalar input feeds N_HID hidden neurons (signed weight, signed bias, clamp activation), then one output neuron (signed weights over hidden outputs, signed bias, clamp). A single multiplier-accumulator is stepped by an FSM, so cost stays flat as N_HID grows. Weights and biases are runtime-loadable through a config write port. The block sits between the input pins and the output register stage with valid/ready on both sides.

## Interface
- DATA_W, 8: width of input sample, hidden activations, output.
- WGT_W, 8: width of every weight and bias, two's complement.
- N_HID, 2: hidden neuron count, ≥1.
- (localparam) CFG_AW = $clog2(3*N_HID+1); ACC_W = DATA_W+WGT_W+$clog2(N_HID+1)+2, signed.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample.
- in_data  in  DATA_W  unsigned sample x.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  DATA_W  unsigned result.
- cfg_we  in  1  write strobe.
- cfg_addr  in  CFG_AW  0..N_HID-1 = w[i]; N_HID..2N_HID-1 = b[i]; 2N_HID..3N_HID-1 = v[i]; 3N_HID = c.
- cfg_wdata  in  WGT_W  signed coefficient.
- sat_flag  out  1  sticky saturation indicator (see Configuration).

## Operation
- Hidden: h[i] = clamp(x·w[i] + b[i]); output: y = clamp(Σ v[i]·h[i] + c). x, h unsigned; w, b, v, c sign-extended to ACC_W; all arithmetic signed at ACC_W, no intermediate wrap.
- clamp(z): z<0 → 0; z>2^DATA_W−1 → 2^DATA_W−1 (upper clamp = "saturation event"); else z[DATA_W−1:0].
- FSM states: IDLE, HID, OUT, FIN, DONE.
  - IDLE: in_ready=1. On in_valid&&in_ready: latch x, idx←0, acc←0, go HID.
  - HID: one hidden neuron per cycle, h[idx] registered; after idx=N_HID−1, idx←0, go OUT.
  - OUT: acc += v[idx]·h[idx], one per cycle; after idx=N_HID−1 go FIN.
  - FIN: out_data←clamp(acc+c), go DONE.
  - DONE: out_valid=1, out_data stable. On out_ready go IDLE.
- in_ready=1 only in IDLE; in_valid outside IDLE ignored; in_data sampled only on accept.
- Config writes honoured only in IDLE; writes in any other state, or cfg_addr > 3N_HID, are ignored (no side effect). A write coincident with an input accept takes effect and is used by that sample.
- Reset (any time, including mid-computation): state IDLE, in_ready=1, out_valid=0, out_data=0, all coefficients 0, h[] 0, acc 0, sat_flag 0. In-flight sample is discarded.

## Timing
- Accept on edge k; out_valid rises after edge k+2·N_HID+2 (N_HID=2: 6 cycles).
- Result held indefinitely while out_ready=0.
- out_valid falls and in_ready rises on the edge after out_valid&&out_ready; next accept earliest one cycle later. Max throughput: one sample per 2·N_HID+4 cycles.
- in_ready, out_valid decoded from registered state only; no combinational in→out path.

## Configuration
- NN_SAT_FLAG_EN defined: sat_flag set on any saturation event (any h[i] or y) and stays set until reset.
- Not defined: sat_flag tied to 0, detection logic absent; datapath results identical.

## Test plan
- Load w=(2,1), b=(10,20), v=(1,2), c=5 (N_HID=2); x=3 → out_data=67 exactly 6 cycles after accept; sat_flag=0.
- Same coefficients, x=100 → h=(210,120), out_data=255; sat_flag=1 with macro, 0 without; flag persists through next x=3 (result 67).
- w=(−1,1), rest as above, x=50 → h=(0,70), out_data=145 (lower clamp, no saturation event).
- x=3 accepted, hold out_ready=0 for 10 cycles while toggling in_valid and cfg_we with cfg_addr=0/cfg_wdata=7 → out_data stays 67, in_ready=0, no new accept; then x=3 again → 67 (w[0] write ignored).
- Assert rst_n low during OUT state → out_valid=0, out_data=0, in_ready=1 immediately; after reload of coefficients, x=3 → 67; without reload, any x → 0.
- Write cfg_addr=7 (out of range) in IDLE → no coefficient changes; x=3 still → 67.
